pie_cmd_tx: RTL and testbench

//  Reader-side PIE encoder: serialises an interrogator command into EPC Gen2 (6C) PIE envelope on pie_out.

---
 rtl/pie_pkg.sv | 30 +++
 rtl/pie_sym_timer.sv | 27 ++
 rtl/pie_cmd_tx.sv | 196 +++++++++++++++++++
 tb/tb_pie_cmd_tx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pie_pkg.sv
// Shared types and default timing for the reader-side PIE command encoder.
// Lengths are in clk_1_92m cycles; one Tari is 12 cycles.
package pie_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DELIM,
    ST_D0,
    ST_RTCAL,
    ST_TRCAL,
    ST_DATA
  } pie_state_e;

  typedef enum logic {
    PH_HIGH,
    PH_LOW
  } pie_phase_e;

  localparam int DEF_TARI_LEN  = 12;
  localparam int DEF_PW_LEN    = 6;
  localparam int DEF_DATA1_LEN = 24;
  localparam int DEF_DELIM_LEN = 24;
  localparam int DEF_CNT_W     = 10;

  // A PIE symbol of total length len spends len-pw cycles high before its low pulse.
  function automatic int high_len(input int len, input int pw);
    return len - pw;
  endfunction

endpackage

// File: rtl/pie_sym_timer.sv
// Phase timer: load captures len-1, counts down to 0 and holds; o_expire marks the final cycle of a phase.
// Latency: o_expire is high in the len-th cycle after the load edge.
module pie_sym_timer #(
  parameter int CNT_W = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_len,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_len - CNT_W'(1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/pie_cmd_tx.sv
// Serialises one Gen2 interrogator command into a PIE envelope: delimiter, data-0, RTcal, TRcal or frame-sync, data.
// pie_out is registered; bit_ready is combinational and only high in the final low cycle before the next data symbol.
module pie_cmd_tx
  import pie_pkg::*;
#(
  parameter int TARI_LEN  = DEF_TARI_LEN,
  parameter int PW_LEN    = DEF_PW_LEN,
  parameter int DATA1_LEN = DEF_DATA1_LEN,
  parameter int DELIM_LEN = DEF_DELIM_LEN,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             i_clk_1_92m,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_preamble_sel,
  input  logic [CNT_W-1:0] i_trcal_cnt,
  input  logic             i_bit_data,
  input  logic             i_bit_last,
  input  logic             i_bit_valid,
  output logic             o_bit_ready,
  output logic             o_pie_out,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_underrun
);

  localparam logic [CNT_W-1:0] L_DELIM  = CNT_W'(DELIM_LEN);
  localparam logic [CNT_W-1:0] L_PW     = CNT_W'(PW_LEN);
  localparam logic [CNT_W-1:0] L_D0_HI  = CNT_W'(high_len(TARI_LEN, PW_LEN));
  localparam logic [CNT_W-1:0] L_D1_HI  = CNT_W'(high_len(DATA1_LEN, PW_LEN));
  localparam logic [CNT_W-1:0] L_RT_HI  = CNT_W'(high_len(TARI_LEN + DATA1_LEN, PW_LEN));
  localparam logic [CNT_W-1:0] L_TR_MIN = CNT_W'(2 * PW_LEN);

  pie_state_e       r_state;
  pie_phase_e       r_phase;
  logic             r_preamble;
  logic [CNT_W-1:0] r_tr_hi;
  logic             r_last;
  logic             r_pie_out;
  logic             r_done;
  logic             r_underrun;

  pie_state_e       w_nxt_state;
  pie_phase_e       w_nxt_phase;
  logic             w_load;
  logic [CNT_W-1:0] w_len;
  logic             w_expire;
  logic             w_boundary;
  logic             w_bit_ready;
  logic             w_take_bit;
  logic             w_start_acc;
  logic             w_done_nxt;
  logic             w_underrun_nxt;
  logic             w_nxt_pie;
  logic [CNT_W-1:0] w_tr_sat;

  pie_sym_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .i_clk    (i_clk_1_92m),
    .i_rst    (i_rst),
    .i_load   (w_load),
    .i_len    (w_len),
    .o_expire (w_expire)
  );

  // TRcal shorter than two pulse widths cannot hold a high phase, so clamp it.
  assign w_tr_sat = (i_trcal_cnt < L_TR_MIN) ? L_TR_MIN : i_trcal_cnt;

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_phase    = r_phase;
    w_load         = 1'b0;
    w_len          = '0;
    w_boundary     = 1'b0;
    w_bit_ready    = 1'b0;
    w_take_bit     = 1'b0;
    w_start_acc    = 1'b0;
    w_done_nxt     = 1'b0;
    w_underrun_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // The done cycle already shows IDLE but still belongs to the finished frame.
        if (i_start && !r_done) begin
          w_start_acc = 1'b1;
          w_nxt_state = ST_DELIM;
          w_nxt_phase = PH_LOW;
          w_load      = 1'b1;
          w_len       = L_DELIM;
        end
      end
      ST_DELIM: begin
        if (w_expire) begin
          w_nxt_state = ST_D0;
          w_nxt_phase = PH_HIGH;
          w_load      = 1'b1;
          w_len       = L_D0_HI;
        end
      end
      ST_D0, ST_RTCAL, ST_TRCAL, ST_DATA: begin
        if (w_expire) begin
          if (r_phase == PH_HIGH) begin
            w_nxt_phase = PH_LOW;
            w_load      = 1'b1;
            w_len       = L_PW;
          end else begin
            case (r_state)
              ST_D0: begin
                w_nxt_state = ST_RTCAL;
                w_nxt_phase = PH_HIGH;
                w_load      = 1'b1;
                w_len       = L_RT_HI;
              end
              ST_RTCAL: begin
                if (r_preamble) begin
                  w_nxt_state = ST_TRCAL;
                  w_nxt_phase = PH_HIGH;
                  w_load      = 1'b1;
                  w_len       = r_tr_hi;
                end else begin
                  w_boundary = 1'b1;
                end
              end
              ST_TRCAL: w_boundary = 1'b1;
              default: begin
                if (r_last) begin
                  w_nxt_state = ST_IDLE;
                  w_nxt_phase = PH_HIGH;
                  w_done_nxt  = 1'b1;
                end else begin
                  w_boundary = 1'b1;
                end
              end
            endcase
          end
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_phase = PH_HIGH;
      end
    endcase

    if (w_boundary) begin
      w_bit_ready = 1'b1;
      if (i_bit_valid) begin
        w_take_bit  = 1'b1;
        w_nxt_state = ST_DATA;
        w_nxt_phase = PH_HIGH;
        w_load      = 1'b1;
        w_len       = i_bit_data ? L_D1_HI : L_D0_HI;
      end else begin
        w_nxt_state    = ST_IDLE;
        w_nxt_phase    = PH_HIGH;
        w_underrun_nxt = 1'b1;
      end
    end
  end

  assign w_nxt_pie = !((w_nxt_state == ST_DELIM) ||
                       ((w_nxt_state != ST_IDLE) && (w_nxt_phase == PH_LOW)));

  always_ff @(posedge i_clk_1_92m) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_phase    <= PH_HIGH;
      r_preamble <= 1'b0;
      r_tr_hi    <= '0;
      r_last     <= 1'b0;
      r_pie_out  <= 1'b1;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_phase    <= w_nxt_phase;
      r_pie_out  <= w_nxt_pie;
      r_done     <= w_done_nxt;
      r_underrun <= w_underrun_nxt;
      if (w_start_acc) begin
        r_preamble <= i_preamble_sel;
        r_tr_hi    <= w_tr_sat - L_PW;
      end
      if (w_take_bit) begin
        r_last <= i_bit_last;
      end
    end
  end

  assign o_bit_ready = w_bit_ready;
  assign o_pie_out   = r_pie_out;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = r_done;
  assign o_underrun  = r_underrun;

endmodule

// File: tb/tb_pie_cmd_tx.sv
// Scoreboard bench: expected PIE run lengths and end-of-frame events are queued per frame;
// a negedge monitor measures in-frame runs of pie_out and pops/compares independently of the driver.
module tb_pie_cmd_tx;

  localparam int TARI  = 12;
  localparam int PW    = 6;
  localparam int DATA1 = 24;
  localparam int DELIM = 24;
  localparam int CW    = 10;

  typedef struct {
    bit lvl;
    int len;
  } seg_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          preamble_sel = 1'b0;
  logic [CW-1:0] trcal_cnt = '0;
  logic          bit_data = 1'b0;
  logic          bit_last = 1'b0;
  logic          bit_valid = 1'b0;
  logic          bit_ready;
  logic          pie_out;
  logic          busy;
  logic          done;
  logic          underrun;

  int   total = 0;
  int   bad = 0;
  seg_t segq[$];
  int   evq[$];
  bit   bits[16];

  pie_cmd_tx dut (
    .i_clk_1_92m    (clk),
    .i_rst          (rst),
    .i_start        (start),
    .i_preamble_sel (preamble_sel),
    .i_trcal_cnt    (trcal_cnt),
    .i_bit_data     (bit_data),
    .i_bit_last     (bit_last),
    .i_bit_valid    (bit_valid),
    .o_bit_ready    (bit_ready),
    .o_pie_out      (pie_out),
    .o_busy         (busy),
    .o_done         (done),
    .o_underrun     (underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: every PIE symbol of total length L is (L-PW) cycles of CW then a PW-cycle low pulse.
  task automatic push_sym(input int len);
    segq.push_back('{1'b1, len - PW});
    segq.push_back('{1'b0, PW});
  endtask

  task automatic model_frame(input bit pre, input int trcal, input int n);
    segq.push_back('{1'b0, DELIM});
    push_sym(TARI);
    push_sym(TARI + DATA1);
    if (pre) push_sym((trcal < 2 * PW) ? 2 * PW : trcal);
    if (n == 0) begin
      evq.push_back(2);
    end else begin
      for (int i = 0; i < n; i++) push_sym(bits[i] ? DATA1 : TARI);
      evq.push_back(1);
    end
  endtask

  // Monitor: a run counts only if busy was high for all of it (excludes idle CW and reset-truncated runs).
  logic run_lvl = 1'b1;
  int   run_len = 0;
  bit   run_ok = 1'b0;

  always @(negedge clk) begin
    seg_t s;
    int   ev;
    if (pie_out !== run_lvl) begin
      if (run_ok) begin
        if (segq.size() == 0) begin
          chk("seg_unexpected", run_len, 0);
        end else begin
          s = segq.pop_front();
          chk("seg_level", 32'(run_lvl), 32'(s.lvl));
          chk("seg_length", run_len, s.len);
        end
      end
      run_lvl = pie_out;
      run_len = 1;
      run_ok  = (busy === 1'b1);
    end else begin
      run_len++;
      if (busy !== 1'b1) run_ok = 1'b0;
    end

    if (done === 1'b1 || underrun === 1'b1) begin
      if (evq.size() == 0) begin
        chk("event_unexpected", {done, underrun}, 0);
      end else begin
        ev = evq.pop_front();
        chk("event_kind", done ? 1 : 2, ev);
        chk("end_pie_high", 32'(pie_out), 1);
        chk("end_busy_low", 32'(busy), 0);
        chk("end_ready_low", 32'(bit_ready), 0);
        chk("end_one_hot", 32'(done & underrun), 0);
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_pie_low", 32'(pie_out), 0);
    chk("start_busy", 32'(busy), 1);
  endtask

  task automatic present_bit(input int idx, input int n);
    bit_valid = (idx < n);
    bit_data  = (idx < n) ? bits[idx] : 1'b0;
    bit_last  = (idx == n - 1);
  endtask

  // n == 0 withholds bit_valid to force an underrun at the first boundary.
  task automatic run_frame(input bit pre, input int trcal, input int n, input bit poke);
    int idx = 0;
    int hs_cnt = 0;
    bit fin = 1'b0;
    bit poked = 1'b0;
    preamble_sel = pre;
    trcal_cnt    = CW'(trcal);
    model_frame(pre, trcal, n);
    present_bit(0, n);
    pulse_start();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (done || underrun) begin
        fin = 1'b1;
        break;
      end
      if (bit_ready && bit_valid) begin
        hs_cnt++;
        idx++;
      end
      @(posedge clk);
      #1;
      present_bit(idx, n);
      start = 1'b0;
      if (poke && hs_cnt == 1 && !poked) begin
        start = 1'b1;
        poked = 1'b1;
      end
    end
    chk("frame_finished", 32'(fin), 1);
    chk("handshakes", hs_cnt, n);
    bit_valid = 1'b0;
    if (poke) begin
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (40) @(negedge clk);
      chk("start_ignored", 32'(busy), 0);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_pie", 32'(pie_out), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ready", 32'(bit_ready), 0);
    chk("rst_underrun", 32'(underrun), 0);

    bits[0] = 1'b1; bits[1] = 1'b0;
    run_frame(1'b0, 0, 2, 1'b0);
    bits[0] = 1'b0;
    run_frame(1'b1, 64, 1, 1'b0);
    bits[0] = 1'b1;
    run_frame(1'b1, 5, 1, 1'b0);
    run_frame(1'b0, 0, 0, 1'b0);
    run_frame(1'b1, 30, 0, 1'b0);
    bits[0] = 1'b1; bits[1] = 1'b0;
    run_frame(1'b0, 0, 2, 1'b1);

    // Reset in RTcal high phase: only delimiter and data-0 complete.
    segq.push_back('{1'b0, DELIM});
    push_sym(TARI);
    preamble_sel = 1'b0;
    pulse_start();
    repeat (46) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_pie", 32'(pie_out), 1);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_segs_left", segq.size(), 0);
    @(posedge clk);
    bits[0] = 1'b0; bits[1] = 1'b1; bits[2] = 1'b1;
    run_frame(1'b0, 0, 3, 1'b0);

    for (int f = 0; f < 24; f++) begin
      n = $urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 8);
      for (int i = 0; i < 16; i++) bits[i] = 1'($urandom_range(0, 1));
      run_frame(1'($urandom_range(0, 1)), $urandom_range(0, 80), n, 1'b0);
    end

    repeat (5) @(negedge clk);
    chk("segq_drained", segq.size(), 0);
    chk("evq_drained", evq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
